// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Captures up to LANES retired-instruction records per cycle (lane 0 oldest)
//   into a FIFO and drains one record per cycle over a valid/ready port.
//   Capture is gated by an arm/trigger/limit FSM. When the FIFO is full it
//   either requests a core stall (stall_mode = 1) or drops and counts the
//   overflow (stall_mode = 0).
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   ret_*            per-lane retire records, lane i at slice i
//   arm              one-cycle pulse, OFF/DONE -> ARMED or CAPTURE
//   trig_en/trig_pc  PC trigger enable and value
//   limit            records to capture after arm/trigger, 0 = unlimited
//   stall_mode       1 = hold the core when nearly full, 0 = drop
//   hold             core stall request
//   out_*            FIFO head record, valid/ready handshake
//   drop_cnt         saturating count of records lost for lack of space
//   state            0 OFF, 1 ARMED, 2 CAPTURE, 3 DONE
//   count            FIFO occupancy
module retire_trace_buffer #(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PCW   = 30,
   parameter int unsigned CNTW  = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [LANES-1:0]          ret_valid,
   input  logic [LANES*PCW-1:0]      ret_pc,
   input  logic [LANES*32-1:0]       ret_inst,
   input  logic [LANES*2-1:0]        ret_kind,
   input  logic [LANES*5-1:0]        ret_rd,
   input  logic [LANES*32-1:0]       ret_data,
   input  logic [LANES*32-1:0]       ret_addr,
   input  logic                      arm,
   input  logic                      trig_en,
   input  logic [PCW-1:0]            trig_pc,
   input  logic [CNTW-1:0]           limit,
   input  logic                      stall_mode,
   output logic                      hold,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                out_lane,
   output logic [PCW-1:0]            out_pc,
   output logic [31:0]               out_inst,
   output logic [1:0]                out_kind,
   output logic [4:0]                out_rd,
   output logic [31:0]               out_data,
   output logic [31:0]               out_addr,
   output logic [CNTW-1:0]           drop_cnt,
   output logic [1:0]                state,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CW   = PTRW + 1;

   typedef enum logic [1:0] {
      StOff     = 2'd0,
      StArmed   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } state_e;

   typedef struct packed {
      logic [1:0]     lane;
      logic [PCW-1:0] pc;
      logic [31:0]    inst;
      logic [1:0]     kind;
      logic [4:0]     rd;
      logic [31:0]    data;
      logic [31:0]    addr;
   } rec_t;

   state_e          state_q, state_d;
   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CNTW-1:0] cap_cnt_q, cap_cnt_d;
   logic [CNTW-1:0] drop_q, drop_d;
   rec_t            mem_q [DEPTH];
   rec_t            mem_d [DEPTH];

   rec_t            lane_rec [LANES];
   logic [LANES-1:0] cand;
   logic [LANES-1:0] keep;
   logic            trig_hit;
   logic            pop;
   logic            lim_hit;
   logic [CNTW-1:0] cap_run;
   logic [CW-1:0]   free_slots;
   logic [CW-1:0]   n_push;
   logic [2:0]      n_drop;
   logic [PTRW-1:0] slot;
   logic [CNTW:0]   drop_sum;
   rec_t            head;

   // Unpack the flat lane buses into records.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lane_rec[i].lane = 2'(i);
         lane_rec[i].pc   = ret_pc[i*PCW +: PCW];
         lane_rec[i].inst = ret_inst[i*32 +: 32];
         lane_rec[i].kind = ret_kind[i*2 +: 2];
         lane_rec[i].rd   = ret_rd[i*5 +: 5];
         lane_rec[i].data = ret_data[i*32 +: 32];
         lane_rec[i].addr = ret_addr[i*32 +: 32];
      end
   end

   always_comb begin
      state_d    = state_q;
      cap_cnt_d  = cap_cnt_q;
      cand       = '0;
      keep       = '0;
      trig_hit   = 1'b0;
      pop        = (count_q != '0) && out_ready;
      cap_run    = cap_cnt_q;
      free_slots = CW'(DEPTH) - count_q + CW'(pop);
      n_push     = '0;
      n_drop     = '0;

      // Candidate lanes for this cycle. In ARMED the trigger is the lowest
      // valid lane whose PC matches; it and all valid lanes above it count.
      unique case (state_q)
         StArmed: begin
            for (int i = 0; i < LANES; i++) begin
               if (ret_valid[i] && (ret_pc[i*PCW +: PCW] == trig_pc)) begin
                  trig_hit = 1'b1;
               end
               if (trig_hit && ret_valid[i]) begin
                  cand[i] = 1'b1;
               end
            end
         end
         StCapture: cand = ret_valid;
         StOff, StDone: cand = '0;
      endcase

      // Apply the capture limit first (excess is silently discarded), then
      // FIFO space: the lowest lanes get the free slots, the rest are lost
      // and counted in drop_cnt.
      for (int i = 0; i < LANES; i++) begin
         if (cand[i] && ((limit == '0) || (cap_run < limit))) begin
            if (cap_run != '1) begin
               cap_run = cap_run + CNTW'(1);
            end
            if (free_slots != '0) begin
               keep[i]    = 1'b1;
               free_slots = free_slots - CW'(1);
               n_push     = n_push + CW'(1);
            end else begin
               n_drop = n_drop + 3'd1;
            end
         end
      end

      lim_hit   = (limit != '0) && (cap_run >= limit);
      cap_cnt_d = cap_run;

      unique case (state_q)
         StOff, StDone: begin
            if (arm) begin
               cap_cnt_d = '0;
               state_d   = trig_en ? StArmed : StCapture;
            end
         end
         StArmed: begin
            if (trig_hit) begin
               state_d = lim_hit ? StDone : StCapture;
            end
         end
         StCapture: begin
            if (lim_hit) begin
               state_d = StDone;
            end
         end
      endcase
   end

   // Compacted write of kept lanes starting at the write pointer.
   always_comb begin
      mem_d = mem_q;
      slot  = wr_ptr_q;
      for (int i = 0; i < LANES; i++) begin
         if (keep[i]) begin
            mem_d[slot] = lane_rec[i];
            slot        = slot + PTRW'(1);
         end
      end
      wr_ptr_d = slot;
      rd_ptr_d = rd_ptr_q + PTRW'(pop);
      count_d  = count_q + n_push - CW'(pop);

      drop_sum = {1'b0, drop_q} + (CNTW+1)'(n_drop);
      drop_d   = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StOff;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         cap_cnt_q <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         cap_cnt_q <= cap_cnt_d;
         drop_q    <= drop_d;
      end
   end

   // Storage needs no reset: outputs are forced to zero while empty.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   always_comb begin
      head      = mem_q[rd_ptr_q];
      out_valid = (count_q != '0);
      out_lane  = out_valid ? head.lane : '0;
      out_pc    = out_valid ? head.pc   : '0;
      out_inst  = out_valid ? head.inst : '0;
      out_kind  = out_valid ? head.kind : '0;
      out_rd    = out_valid ? head.rd   : '0;
      out_data  = out_valid ? head.data : '0;
      out_addr  = out_valid ? head.addr : '0;
      hold      = stall_mode && ((state_q == StArmed) || (state_q == StCapture)) &&
                  ((CW'(DEPTH) - count_q) < CW'(LANES));
      drop_cnt  = drop_q;
      state     = state_q;
      count     = count_q;
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

   localparam int unsigned LANES = 2;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PCW   = 30;
   localparam int unsigned CNTW  = 16;

   logic                   CLK = 1'b0;
   logic                   RST;
   logic [LANES-1:0]       ret_valid;
   logic [LANES*PCW-1:0]   ret_pc;
   logic [LANES*32-1:0]    ret_inst;
   logic [LANES*2-1:0]     ret_kind;
   logic [LANES*5-1:0]     ret_rd;
   logic [LANES*32-1:0]    ret_data;
   logic [LANES*32-1:0]    ret_addr;
   logic                   arm;
   logic                   trig_en;
   logic [PCW-1:0]         trig_pc;
   logic [CNTW-1:0]        limit;
   logic                   stall_mode;
   logic                   hold;
   logic                   out_valid;
   logic                   out_ready;
   logic [1:0]             out_lane;
   logic [PCW-1:0]         out_pc;
   logic [31:0]            out_inst;
   logic [1:0]             out_kind;
   logic [4:0]             out_rd;
   logic [31:0]            out_data;
   logic [31:0]            out_addr;
   logic [CNTW-1:0]        drop_cnt;
   logic [1:0]             state;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_errors = 0;

   retire_trace_buffer #(
      .LANES(LANES), .DEPTH(DEPTH), .PCW(PCW), .CNTW(CNTW)
   ) dut (
      .CLK(CLK), .RST(RST),
      .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst), .ret_kind(ret_kind),
      .ret_rd(ret_rd), .ret_data(ret_data), .ret_addr(ret_addr),
      .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .limit(limit),
      .stall_mode(stall_mode), .hold(hold),
      .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane), .out_pc(out_pc),
      .out_inst(out_inst), .out_kind(out_kind), .out_rd(out_rd), .out_data(out_data),
      .out_addr(out_addr), .drop_cnt(drop_cnt), .state(state), .count(count)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks sample there too.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [PCW-1:0] pc, input logic [31:0] inst,
                           input logic [1:0] kind, input logic [31:0] addr);
      ret_pc[i*PCW +: PCW] = pc;
      ret_inst[i*32 +: 32] = inst;
      ret_kind[i*2 +: 2]   = kind;
      ret_rd[i*5 +: 5]     = 5'(i + 1);
      ret_data[i*32 +: 32] = inst ^ 32'h5A5A_0000;
      ret_addr[i*32 +: 32] = addr;
   endtask

   task automatic retire2(input logic [PCW-1:0] pc0, input logic [PCW-1:0] pc1);
      ret_valid = 2'b11;
      set_lane(0, pc0, 32'h0000_0013, 2'd1, 32'h0);
      set_lane(1, pc1, 32'h0011_2023, 2'd2, 32'h1000_0040);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST        = 1'b1;
      ret_valid  = '0;
      ret_pc     = '0;
      ret_inst   = '0;
      ret_kind   = '0;
      ret_rd     = '0;
      ret_data   = '0;
      ret_addr   = '0;
      arm        = 1'b0;
      trig_en    = 1'b0;
      trig_pc    = '0;
      limit      = '0;
      stall_mode = 1'b1;
      out_ready  = 1'b0;
      tick();
      tick();
      RST = 1'b0;

      // Reset state
      check_eq("rst_state", 64'(state), 64'd0);
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_valid", 64'(out_valid), 64'd0);
      check_eq("rst_hold", 64'(hold), 64'd0);
      check_eq("rst_drop", 64'(drop_cnt), 64'd0);
      check_eq("rst_out_pc", 64'(out_pc), 64'd0);

      // OFF ignores retires
      retire2(30'h10, 30'h11);
      tick();
      ret_valid = '0;
      check_eq("off_count", 64'(count), 64'd0);

      // 1: immediate capture, two lanes in one cycle
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("t1_state", 64'(state), 64'd2);
      check_eq("t1_pre_valid", 64'(out_valid), 64'd0);
      retire2(30'h10, 30'h11);
      out_ready = 1'b1;
      tick();
      ret_valid = '0;
      check_eq("t1_valid", 64'(out_valid), 64'd1);
      check_eq("t1_count2", 64'(count), 64'd2);
      check_eq("t1_pc0", 64'(out_pc), 64'h10);
      check_eq("t1_lane0", 64'(out_lane), 64'd0);
      check_eq("t1_inst0", 64'(out_inst), 64'h13);
      tick();
      check_eq("t1_pc1", 64'(out_pc), 64'h11);
      check_eq("t1_lane1", 64'(out_lane), 64'd1);
      check_eq("t1_kind1", 64'(out_kind), 64'd2);
      check_eq("t1_addr1", 64'(out_addr), 64'h1000_0040);
      check_eq("t1_rd1", 64'(out_rd), 64'd2);
      check_eq("t1_data1", 64'(out_data), 64'h5A4B_2023);
      check_eq("t1_count1", 64'(count), 64'd1);
      tick();
      check_eq("t1_empty", 64'(out_valid), 64'd0);
      check_eq("t1_count0", 64'(count), 64'd0);
      out_ready = 1'b0;

      // 2: PC trigger in lane 1
      do_reset();
      trig_en = 1'b1;
      trig_pc = 30'h3E57;
      arm     = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("t2_armed", 64'(state), 64'd1);
      retire2(30'h100, 30'h101);
      tick();
      check_eq("t2_nomatch_state", 64'(state), 64'd1);
      check_eq("t2_nomatch_count", 64'(count), 64'd0);
      retire2(30'h3E56, 30'h3E57);
      tick();
      ret_valid = '0;
      check_eq("t2_state", 64'(state), 64'd2);
      check_eq("t2_count", 64'(count), 64'd1);
      check_eq("t2_pc", 64'(out_pc), 64'h3E57);
      check_eq("t2_lane", 64'(out_lane), 64'd1);

      // 3: limit of 3 records
      do_reset();
      trig_en = 1'b0;
      limit   = 16'd3;
      arm     = 1'b1;
      tick();
      arm = 1'b0;
      retire2(30'h20, 30'h21);
      tick();
      check_eq("t3_count2", 64'(count), 64'd2);
      check_eq("t3_state_cap", 64'(state), 64'd2);
      retire2(30'h22, 30'h23);
      tick();
      check_eq("t3_count3", 64'(count), 64'd3);
      check_eq("t3_state_done", 64'(state), 64'd3);
      check_eq("t3_drop", 64'(drop_cnt), 64'd0);
      retire2(30'h24, 30'h25);
      tick();
      ret_valid = '0;
      check_eq("t3_done_count", 64'(count), 64'd3);
      check_eq("t3_head", 64'(out_pc), 64'h20);
      out_ready = 1'b1;
      tick();
      check_eq("t3_pop_pc", 64'(out_pc), 64'h21);
      tick();
      check_eq("t3_pop_pc2", 64'(out_pc), 64'h22);
      tick();
      check_eq("t3_drained", 64'(count), 64'd0);
      out_ready = 1'b0;

      // 4: drop mode, overfill with out_ready low (re-arm from DONE)
      limit      = '0;
      stall_mode = 1'b0;
      arm        = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("t4_rearm", 64'(state), 64'd2);
      for (int c = 0; c < 10; c++) begin
         retire2(30'(32'h40 + 2*c), 30'(32'h41 + 2*c));
         tick();
      end
      ret_valid = '0;
      check_eq("t4_count", 64'(count), 64'd16);
      check_eq("t4_drop", 64'(drop_cnt), 64'd4);
      check_eq("t4_head", 64'(out_pc), 64'h40);
      check_eq("t4_hold", 64'(hold), 64'd0);
      tick();
      check_eq("t4_head_stable", 64'(out_pc), 64'h40);
      out_ready = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      out_ready = 1'b0;
      check_eq("t4_count9", 64'(count), 64'd9);
      check_eq("t4_head7", 64'(out_pc), 64'h47);

      // 6: reset mid-capture
      RST = 1'b1;
      tick();
      check_eq("t6_count", 64'(count), 64'd0);
      check_eq("t6_valid", 64'(out_valid), 64'd0);
      check_eq("t6_state", 64'(state), 64'd0);
      check_eq("t6_drop", 64'(drop_cnt), 64'd0);
      RST = 1'b0;

      // 5: stall mode hold near full
      stall_mode = 1'b1;
      arm        = 1'b1;
      tick();
      arm = 1'b0;
      for (int c = 0; c < 7; c++) begin
         retire2(30'(32'h60 + 2*c), 30'(32'h61 + 2*c));
         tick();
      end
      check_eq("t5_count14", 64'(count), 64'd14);
      check_eq("t5_hold14", 64'(hold), 64'd0);
      ret_valid = 2'b01;
      set_lane(0, 30'h6E, 32'h0000_0013, 2'd0, 32'h0);
      tick();
      ret_valid = '0;
      check_eq("t5_count15", 64'(count), 64'd15);
      check_eq("t5_hold15", 64'(hold), 64'd1);
      stall_mode = 1'b0;
      #1;
      check_eq("t5_hold_dropmode", 64'(hold), 64'd0);
      stall_mode = 1'b1;
      #1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("t5_count_pop", 64'(count), 64'd14);
      check_eq("t5_hold_pop", 64'(hold), 64'd0);
      check_eq("t5_head", 64'(out_pc), 64'h61);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
